// File: rtl/keypad_digit_display_pkg.sv
// Shared sizing and constants for the keypad entry / multiplexed display block.
package keypad_digit_display_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int BUF_W   = DIGITS * DIGIT_W;
  localparam int CNT_W   = 3;
  localparam int SEL_W   = 2;

  localparam logic [DIGITS-1:0] BLANK_AN = 4'b1111;

  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [BUF_W-1:0]   digit_buf_t;

  // Entry count saturates once every display position holds a digit.
  function automatic count_t count_inc(input count_t c);
    if (c >= CNT_W'(DIGITS)) begin
      return CNT_W'(DIGITS);
    end
    return c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces a synchronized key level and emits a one-cycle press pulse on the
// debounced 0->1 edge, capturing the key code that was present at that moment.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int VAL_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_i,
  input  logic [VAL_W-1:0] val_i,
  output logic             level_o,
  output logic             press_o,
  output logic [VAL_W-1:0] val_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic [VAL_W-1:0] val_q, val_d;

  // The count only advances while the input disagrees with the debounced
  // level; any cycle of agreement drops it back to zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    val_d   = val_q;
    if (din_i != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = din_i;
        press_d = din_i;
        if (din_i) begin
          val_d = val_i;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      val_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      val_q   <= val_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign val_o   = val_q;

endmodule

// File: rtl/seven_segs.sv
// Hex digit to seven-segment decoder; seg = {g,f,e,d,c,b,a}, segments active-low.
module seven_segs (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/keypad_digit_display.sv
// Keypad entry buffer of four hex digits, shown on a time-multiplexed
// four-position seven-segment display with unentered positions blanked.
module keypad_digit_display
  import keypad_digit_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REFRESH_BITS    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_down,
  input  logic [3:0]   key_val,
  input  logic         clr,
  output logic         key_evt,
  output logic [15:0]  digits,
  output logic [2:0]   entry_count,
  output logic [3:0]   an,
  output logic [6:0]   seg
);

  logic                    kd_s1_q, kd_s2_q;
  digit_t                  kv_s1_q, kv_s2_q;
  logic                    press;
  logic                    level_unused;
  digit_t                  key_code;
  digit_buf_t              digits_q, digits_d;
  count_t                  count_q, count_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [SEL_W-1:0]        sel;
  digit_t                  digit_arr [DIGITS];
  digit_t                  active_digit;

  // key_val rides alongside key_down so both reach the debouncer aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kd_s1_q <= 1'b0;
      kd_s2_q <= 1'b0;
      kv_s1_q <= '0;
      kv_s2_q <= '0;
    end else begin
      kd_s1_q <= key_down;
      kd_s2_q <= kd_s1_q;
      kv_s1_q <= key_val;
      kv_s2_q <= kv_s1_q;
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .VAL_W           (DIGIT_W)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (kd_s2_q),
    .val_i   (kv_s2_q),
    .level_o (level_unused),
    .press_o (press),
    .val_o   (key_code)
  );

  // Clear outranks a coincident press; the press pulse itself is still visible.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clr) begin
      digits_d = '0;
      count_d  = '0;
    end else if (press) begin
      digits_d = {digits_q[BUF_W-DIGIT_W-1:0], key_code};
      count_d  = count_inc(count_q);
    end
  end

  assign refresh_d = refresh_q + REFRESH_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      count_q   <= '0;
      refresh_q <= '0;
    end else begin
      digits_q  <= digits_d;
      count_q   <= count_d;
      refresh_q <= refresh_d;
    end
  end

  assign sel = refresh_q[REFRESH_BITS-1 -: SEL_W];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
    assign digit_arr[gi] = digits_q[gi*DIGIT_W +: DIGIT_W];
    assign an[gi] = ((sel == SEL_W'(gi)) && (CNT_W'(gi) < count_q)) ? 1'b0 : BLANK_AN[gi];
  end

  assign active_digit = digit_arr[sel];

  seven_segs u_segs (
    .hex (active_digit),
    .seg (seg)
  );

  assign key_evt     = press;
  assign digits      = digits_q;
  assign entry_count = count_q;

endmodule

// File: doc/keypad_digit_display.md
KEYPAD_DIGIT_DISPLAY -- requirements
Module: keypad_digit_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, cycles key_down must hold stable before the debounced level changes.
REQ-002 Parameter REFRESH_BITS, default 16, width of display refresh counter; top 2 bits select the active digit.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port key_down  input  1  raw key-pressed level from the keypad scanner, asynchronous to clk.
REQ-006 Port key_val  input  4  hex code of the pressed key; meaningful while key_down=1.
REQ-007 Port clr  input  1  synchronous clear of the entry buffer, active-high.
REQ-008 Port key_evt  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 Port digits  output  16  entry buffer; [3:0] newest digit, [15:12] oldest.
REQ-010 Port entry_count  output  3  digits entered, saturating at 4.
REQ-011 Port an  output  4  digit enables, active-low; an[i] drives display position i (0 = rightmost).
REQ-012 Port seg  output  7  segment pattern of the active digit, same encoding as seven_segs.

Function
REQ-013 key_down and key_val SHALL pass through a 2-flop synchronizer (key_val registered in parallel) before use.
REQ-014 Debounced level SHALL change only after the synchronized key_down differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-015 Press event = debounced level 0->1; key_evt SHALL be high for exactly that one cycle.
REQ-016 On press event: digits <= {digits[11:0], key_val_sync}; entry_count <= min(entry_count+1, 4).
REQ-017 With entry_count=4, a press SHALL discard digits[15:12] (shift-out), count stays 4.
REQ-018 Release (debounced 1->0) SHALL produce no event and no buffer change; holding a key SHALL produce one event only.
REQ-019 clr=1 SHALL zero digits and entry_count next cycle; clr and press in the same cycle: clr wins, event dropped, key_evt still pulses.
REQ-020 Refresh counter SHALL free-run modulo 2^REFRESH_BITS; sel = counter[REFRESH_BITS-1:REFRESH_BITS-2].
REQ-021 an SHALL be one-hot-low at position sel when sel < entry_count, else 4'b1111 (blank unentered positions).
REQ-022 seg SHALL encode digits[4*sel+3:4*sel] combinationally from registered sel and digits.
REQ-023 Latency: key_down rising at the input -> key_evt = 2 sync + DEBOUNCE_CYCLES + 1 cycles (±1 for sampling phase); digits update the cycle after key_evt.

Reset
REQ-024 On rst_n=0, asynchronously: digits=0, entry_count=0, key_evt=0, debounced level=0, debounce count=0, synchronizers=0, refresh counter=0, an=4'b1111.
REQ-025 Reset asserted mid-debounce SHALL abandon the pending event; a key still held after reset release SHALL produce one event after full debounce.

Structure
REQ-026 Shared package holds DIGITS=4, DIGIT_W=4 and the blank anode constant 4'b1111; parameters stay local.
REQ-027 Segment decoding SHALL instantiate the existing seven_segs module; debounce+edge detect SHALL be one sub-module named key_debounce.

Verification
REQ-028 Reset, DEBOUNCE_CYCLES=4: hold key_down=1, key_val=5 for 20 cycles -> one key_evt, digits=0x0005, entry_count=1.
REQ-029 Glitch: key_down high 3 cycles then low (DEBOUNCE_CYCLES=4) -> no key_evt, digits unchanged.
REQ-030 Press 1,2,3,4,5 in sequence -> digits=0x2345, entry_count=4, exactly five key_evt pulses.
REQ-031 entry_count=2, digits=0x0012, REFRESH_BITS=4: over 16 cycles an cycles 1110,1101,1111,1111 and seg shows 2 then 1.
REQ-032 clr coincident with press event -> digits=0, entry_count=0, key_evt=1 that cycle.
REQ-033 rst_n pulsed low mid-debounce with key held -> all outputs reset immediately, one key_evt after DEBOUNCE_CYCLES+3 cycles following release.
